// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and sizing helpers for the serial-in parallel-out deserializer
package sipo_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sipo_state_t;

  localparam int SIPO_DEFAULT_WIDTH = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// rtl/sipo_bit_counter.sv - modulo-WIDTH bit counter with enable, sync clear and last-bit flag
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with one-deep valid/ready output register
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    d_serial,
  input  logic                    d_valid,
  input  logic                    q_ready,
  output logic [WIDTH-1:0]        q_parallel,
  output logic                    q_valid,
  output logic [WIDTH-1:0]        q_shift,
  output logic [cnt_w(WIDTH)-1:0] bit_count,
  output logic                    overrun
);

  localparam int CW = cnt_w(WIDTH);

  sipo_state_t      st;
  logic             last;
  logic             complete;
  logic [WIDTH-1:0] shift_next;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (d_valid),
    .count   (bit_count),
    .last    (last)
  );

  assign shift_next = MSB_FIRST ? {q_shift[WIDTH-2:0], d_serial}
                                : {d_serial, q_shift[WIDTH-1:1]};

  // The completing bit is folded in here so the word lands with zero added latency.
  assign complete = d_valid && last && !clear;

  assign q_valid = (st == ST_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_shift    <= '0;
      q_parallel <= '0;
      overrun    <= 1'b0;
      st         <= ST_EMPTY;
    end else if (clear) begin
      q_shift <= '0;
      overrun <= 1'b0;
      st      <= ST_EMPTY;
    end else begin
      if (d_valid) begin
        q_shift <= shift_next;
      end
      if (complete) begin
        if (st == ST_EMPTY || q_ready) begin
          q_parallel <= shift_next;
          st         <= ST_FULL;
        end else begin
          overrun <= 1'b1;
        end
      end else if (st == ST_FULL && q_ready) begin
        st <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - scoreboard bench for sipo_deser, MSB-first and LSB-first instances
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       d_serial = 1'b0;
  logic       d_valid = 1'b0;
  logic       q_ready = 1'b0;
  logic [3:0] q_parallel, q_shift, l_parallel, l_shift;
  logic       q_valid, overrun, l_valid, l_overrun;
  logic [2:0] bit_count, l_count;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_l[$];
  logic [3:0] got;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .d_serial(d_serial), .d_valid(d_valid),
    .q_ready(q_ready), .q_parallel(q_parallel), .q_valid(q_valid), .q_shift(q_shift),
    .bit_count(bit_count), .overrun(overrun)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .clear(clear), .d_serial(d_serial), .d_valid(d_valid),
    .q_ready(q_ready), .q_parallel(l_parallel), .q_valid(l_valid), .q_shift(l_shift),
    .bit_count(l_count), .overrun(l_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    d_valid = 1'b1;
    d_serial = b;
    tick();
    d_valid = 1'b0;
  endtask

  // Pushes expectations for both bit orders, then shifts the word out MSB first.
  task automatic send_word(input logic [3:0] w, input bit expect_kept);
    if (expect_kept) begin
      exp_q.push_back(w);
      exp_l.push_back({w[0], w[1], w[2], w[3]});
    end
    for (int i = 3; i >= 0; i--) drive_bit(w[i]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_serial = 1'($urandom_range(0, 1));
      d_valid = 1'($urandom_range(0, 1));
      q_ready = 1'($urandom_range(0, 1));
      clear = 1'($urandom_range(0, 1));
      tick();
    end
    total++;
    if ({q_parallel, q_valid, q_shift, bit_count, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL reset_hold: got par=%h vld=%b sh=%h cnt=%0d ovr=%b want all 0",
               q_parallel, q_valid, q_shift, bit_count, overrun);
    end
    d_serial = 1'b0; d_valid = 1'b0; q_ready = 1'b0; clear = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    drive_bit(1'b1);
    drive_bit(1'b0);
    total++;
    if (bit_count !== 3'd2 || q_shift !== 4'b0010) begin
      bad++;
      $display("FAIL pre_async_reset: got cnt=%0d sh=%b want cnt=2 sh=0010", bit_count, q_shift);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({q_parallel, q_valid, q_shift, bit_count, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset: got par=%h vld=%b sh=%h cnt=%0d ovr=%b want all 0 before edge",
               q_parallel, q_valid, q_shift, bit_count, overrun);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    q_ready = 1'b0;
    exp_q.push_back(4'b1011);
    exp_l.push_back(4'b1101);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    total++;
    if (q_shift !== 4'b0101 || q_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_partial: got sh=%b vld=%b want sh=0101 vld=0", q_shift, q_valid);
    end
    drive_bit(1'b1);
    total++;
    if (q_valid !== 1'b1 || l_valid !== 1'b1 || bit_count !== 3'd0) begin
      bad++;
      $display("FAIL basic_valid: got vld=%b lvld=%b cnt=%0d want 1 1 0", q_valid, l_valid, bit_count);
    end
    q_ready = 1'b1;
    total++;
    got = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    if (q_parallel !== got) begin
      bad++;
      $display("FAIL basic_msb_word: got %b want %b", q_parallel, got);
    end
    total++;
    got = (exp_l.size() != 0) ? exp_l.pop_front() : 4'bxxxx;
    if (l_parallel !== got) begin
      bad++;
      $display("FAIL basic_lsb_word: got %b want %b", l_parallel, got);
    end
    tick();
    q_ready = 1'b0;
    total++;
    if (q_valid !== 1'b0 || q_parallel !== 4'b1011) begin
      bad++;
      $display("FAIL basic_accept: got vld=%b par=%b want vld=0 par=1011", q_valid, q_parallel);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] w;
    w = 4'b1011;
    q_ready = 1'b0;
    exp_q.push_back(w);
    exp_l.push_back({w[0], w[1], w[2], w[3]});
    for (int i = 0; i < 4; i++) begin
      drive_bit(w[3-i]);
      repeat (3) tick();
      total++;
      if (bit_count !== 3'((i + 1) % 4)) begin
        bad++;
        $display("FAIL gapped_count%0d: got %0d want %0d", i, bit_count, (i + 1) % 4);
      end
    end
    void'(exp_l.pop_front());
    q_ready = 1'b1;
    total++;
    got = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    if (q_valid !== 1'b1 || q_parallel !== got) begin
      bad++;
      $display("FAIL gapped_word: got vld=%b par=%b want vld=1 par=%b", q_valid, q_parallel, got);
    end
    tick();
    q_ready = 1'b0;
  endtask

  // Consumer takes each held word on the edge that completes the next one, so q_valid never drops.
  task automatic test_back_to_back();
    logic [3:0] words [3];
    words = '{4'b1011, 4'b0110, 4'b1111};
    for (int k = 0; k < 12; k++) begin
      q_ready = (k % 4 == 3) && (k >= 4);
      if (q_ready) begin
        total++;
        got = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
        void'(exp_l.pop_front());
        if (q_parallel !== got) begin
          bad++;
          $display("FAIL stream_word%0d: got %b want %b", k / 4 - 1, q_parallel, got);
        end
      end
      if (k % 4 == 3) begin
        exp_q.push_back(words[k/4]);
        exp_l.push_back({words[k/4][0], words[k/4][1], words[k/4][2], words[k/4][3]});
      end
      drive_bit(words[k/4][3 - k % 4]);
      if (k >= 3) begin
        total++;
        if (q_valid !== 1'b1) begin
          bad++;
          $display("FAIL stream_valid_k%0d: got %b want 1", k, q_valid);
        end
      end
    end
    q_ready = 1'b1;
    total++;
    got = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    void'(exp_l.pop_front());
    if (q_parallel !== got) begin
      bad++;
      $display("FAIL stream_word2: got %b want %b", q_parallel, got);
    end
    tick();
    q_ready = 1'b0;
    total++;
    if (q_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL stream_end: got vld=%b ovr=%b want 0 0", q_valid, overrun);
    end
  endtask

  task automatic test_overrun();
    q_ready = 1'b0;
    send_word(4'b1011, 1'b1);
    send_word(4'b0110, 1'b0);
    total++;
    got = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    void'(exp_l.pop_front());
    if (q_parallel !== got || overrun !== 1'b1 || q_valid !== 1'b1) begin
      bad++;
      $display("FAIL overrun_hold: got par=%b ovr=%b vld=%b want par=%b ovr=1 vld=1",
               q_parallel, overrun, q_valid, got);
    end
    repeat (2) tick();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (overrun !== 1'b0 || q_valid !== 1'b0 || bit_count !== 3'd0) begin
      bad++;
      $display("FAIL overrun_clear: got ovr=%b vld=%b cnt=%0d want 0 0 0", overrun, q_valid, bit_count);
    end
  endtask

  task automatic test_clear_mid();
    q_ready = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    clear = 1'b1;
    d_valid = 1'b1;
    d_serial = 1'b1;
    tick();
    clear = 1'b0;
    d_valid = 1'b0;
    total++;
    if (bit_count !== 3'd0 || q_shift !== 4'b0000 || q_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_mid: got cnt=%0d sh=%b vld=%b want 0 0000 0", bit_count, q_shift, q_valid);
    end
    send_word(4'b0110, 1'b1);
    q_ready = 1'b1;
    total++;
    got = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    void'(exp_l.pop_front());
    if (q_valid !== 1'b1 || q_parallel !== got || overrun !== 1'b0) begin
      bad++;
      $display("FAIL clear_next_word: got vld=%b par=%b ovr=%b want 1 %b 0", q_valid, q_parallel, overrun, got);
    end
    tick();
    q_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_overrun();
    test_clear_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover words want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
